io_port_arbiter: RTL
====================

// Module: io_port_arbiter
// PURPOSE
//   Shares the user-project GPIO pads (mprj_io io_out/io_oeb) between NREQ
//   internal requesters, e.g. the team designs and the pattern/self-test
//   engine that drives mprj_io[7:0] during bring-up.
//   Round-robin arbiter with a registered one-hot grant.
//   Inserts a one-cycle all-input turnaround between owners so no two
//   requesters drive a pad in the same cycle.
//   Sits between the requester blocks and the user_project_wrapper IO pins.
// PARAMETERS
//   NREQ        4    number of requesters (2..8)
//   IOW         38   pad count (io_out/io_oeb width per requester)
//   MAX_TENURE  256  cycles an owner may hold while others wait (timeout build only)
// PORTS
//   wb_clk_i     in   1         single clock
//   wb_rst_i     in   1         reset; asynchronous, active-high
//   req_i        in   NREQ      per-requester request; level, held while access is wanted
//   req_out_i    in   NREQ*IOW  flattened io_out per requester; slice k = [k*IOW +: IOW]
//   req_oeb_i    in   NREQ*IOW  flattened io_oeb per requester (1 = pad is input)
//   grant_o      out  NREQ      one-hot grant, registered; all 0 when no owner
//   owner_o      out  3         index of current owner; valid only while busy_o=1
//   busy_o       out  1         1 in GRANT state
//   io_out       out  IOW       pad output value
//   io_oeb       out  IOW       pad output enable, active-low
// BEHAVIOUR
//   Reset values: grant_o=0, owner_o=0, busy_o=0, io_out=0, io_oeb=all 1,
//     rr_ptr=0, tenure=0, state=IDLE. Reset is asynchronous: asserting
//     wb_rst_i mid-grant forces these values immediately.
//   States: IDLE, GRANT, TURN.
//   Arbitration (IDLE or TURN, any req_i set):
//     - Pick the first set req_i searching upward from rr_ptr, with wrap-around.
//     - Next edge: state=GRANT, grant_o one-hot, owner_o=winner, tenure=0.
//     - req_i seen at edge N -> grant_o high after edge N+1; latency 1 cycle.
//   IDLE with no req_i: stay IDLE.
//   GRANT:
//     - io_out/io_oeb = owner's slice (combinational mux gated by state).
//     - tenure increments each cycle and saturates at MAX_TENURE-1.
//   GRANT exit: owner's req_i=0, or preemption (timeout build only).
//     - Next state TURN; grant_o=0; rr_ptr=(owner+1) mod NREQ.
//   TURN: exactly 1 cycle. io_oeb=all 1, io_out=0, busy_o=0.
//     - Then arbitrate as in IDLE, or go to IDLE if no req_i is set.
//   Outside GRANT, io_out=0 and io_oeb=all 1.
//   Owner drops req_i and preemption fires in the same cycle: single TURN,
//     same pointer update.
//   Owner re-asserts req_i during TURN: competes normally. rr_ptr already
//     points past it, so other pending requesters win first.
//   Single requester: back-to-back tenures are separated by one TURN cycle.
//   Non-owner req_i changes during GRANT have no effect on the outputs.
// CONFIGURATION
//   IO_ARB_TIMEOUT_EN defined:
//     - In GRANT, if tenure==MAX_TENURE-1 and any other req_i is set, the
//       owner is preempted: next state TURN, regardless of its req_i.
//     - If no other requester is waiting, the owner keeps the grant and
//       tenure stays saturated.
//   IO_ARB_TIMEOUT_EN undefined:
//     - No tenure counter; owner holds until it drops req_i.
//     - MAX_TENURE is ignored.
// TESTING (NREQ=4, IOW=38, MAX_TENURE=8)
//   1. Reset, hold req_i=0 for 20 cycles
//      -> grant_o=0, io_oeb=38'h3F_FFFF_FFFF, io_out=0 throughout.
//   2. req_i=4'b0100, slice2 out=38'h0A, oeb=38'h3F_FFFF_FF00
//      -> grant_o=4'b0100 one cycle later; io_out[7:0]=8'h0A; owner_o=2.
//   3. req_i=4'b1111 from IDLE with rr_ptr=0, each dropping after 3 grant cycles
//      -> owners 0,1,2,3 in order, each tenure followed by exactly one TURN
//         cycle with io_oeb all 1.
//   4. Timeout build: owner 1 holds req, req 3 asserted
//      -> after 8 GRANT cycles: TURN, then grant_o=4'b1000.
//      Non-timeout build: owner 1 keeps the grant indefinitely.
//   5. Assert wb_rst_i mid-GRANT, between clock edges
//      -> grant_o=0, io_oeb all 1 with no clock edge; after release,
//         owner 0 is picked first.
//   6. Owner drops req_i on the same cycle as timeout
//      -> one TURN cycle, rr_ptr=owner+1, no double pointer advance.

Source files
------------

// File: rtl/io_port_arbiter.sv
// rtl/io_port_arbiter.sv - round-robin GPIO pad arbiter with one-cycle turnaround between owners
// Optional owner preemption after MAX_TENURE cycles: define IO_ARB_TIMEOUT_EN.
module io_port_arbiter #(
    parameter int NREQ       = 4,
    parameter int IOW        = 38,
    parameter int MAX_TENURE = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*IOW-1:0] req_out_i,
    input  logic [NREQ*IOW-1:0] req_oeb_i,
    output logic [NREQ-1:0]     grant_o,
    output logic [2:0]          owner_o,
    output logic                busy_o,
    output logic [IOW-1:0]      io_out,
    output logic [IOW-1:0]      io_oeb
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    if (NREQ < 2 || NREQ > 8 || MAX_TENURE < 2) begin : g_bad_cfg
        $error("io_port_arbiter: unsupported NREQ/MAX_TENURE");
    end

    state_t          state, state_nx;
    logic [2:0]      rr_ptr, rr_ptr_nx, owner_nx, winner;
    logic [NREQ-1:0] grant_nx;
    logic            found, owner_req, others_req, preempt;
    int              idx;

    assign owner_req  = |(req_i & grant_o);
    assign others_req = |(req_i & ~grant_o);

`ifdef IO_ARB_TIMEOUT_EN
    localparam int TW = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
    localparam logic [TW-1:0] TMAX = TW'(MAX_TENURE - 1);
    logic [TW-1:0] tenure;

    assign preempt = (state == GRANT) && (tenure == TMAX) && others_req;

    // Cleared outside GRANT so every tenure starts from 0.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tenure <= '0;
        end else if (state == GRANT) begin
            if (tenure != TMAX) tenure <= tenure + 1'b1;
        end else begin
            tenure <= '0;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant_o;
        owner_nx  = owner_o;
        rr_ptr_nx = rr_ptr;
        unique case (state)
            IDLE, TURN: begin
                grant_nx = '0;
                if (found) begin
                    state_nx = GRANT;
                    owner_nx = winner;
                    for (int k = 0; k < NREQ; k++) grant_nx[k] = (3'(k) == winner);
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || preempt) begin
                    state_nx  = TURN;
                    grant_nx  = '0;
                    rr_ptr_nx = (owner_o == 3'(NREQ - 1)) ? 3'd0 : owner_o + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant_o <= '0;
            owner_o <= 3'd0;
            rr_ptr  <= 3'd0;
        end else begin
            grant_o <= grant_nx;
            owner_o <= owner_nx;
            rr_ptr  <= rr_ptr_nx;
        end
    end

    assign busy_o = (state == GRANT);

    // One-hot OR mux; gating by state keeps pads released during TURN and reset.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (state == GRANT) begin
            io_oeb = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (grant_o[k]) begin
                    io_out = io_out | req_out_i[k*IOW +: IOW];
                    io_oeb = io_oeb | req_oeb_i[k*IOW +: IOW];
                end
            end
        end
    end

endmodule
